// File: rtl/run_generator.sv
// run_generator: serial stimulus source for the consecutive-ones detectors.
// Emits reps x (run_len ones + gap_len zeros) on x, together with the
// registered golden detector output expect_y. All outputs are registered
// and are computed from the next state, so x and expect_y change together.
module run_generator #(
   parameter int W      = 4,
   parameter int STREAK = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] run_len,
   input  logic [W-1:0] gap_len,
   input  logic [W-1:0] reps,
   output logic         x,
   output logic         expect_y,
   output logic         busy,
   output logic         done
);

   localparam int SW = $clog2(STREAK + 1);
   localparam logic [W-1:0]  CNT_ONE  = W'(1);
   localparam logic [W-1:0]  CNT_ZERO = W'(0);
   localparam logic [SW-1:0] STK_MAX  = SW'(STREAK);
   localparam logic [SW-1:0] STK_ONE  = SW'(1);
   localparam logic [SW-1:0] STK_ZERO = SW'(0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [W-1:0]  cnt_r, cnt_s;          // bits left in current phase, incl. current
   logic [W-1:0]  reps_r, reps_s;        // run+gap pairs left, incl. current
   logic [W-1:0]  run_len_r, run_len_s;
   logic [W-1:0]  gap_len_r, gap_len_s;
   logic [SW-1:0] streak_r, streak_s;
   logic [SW-1:0] streak_inc_s;
   logic          x_r, x_s;
   logic          expect_y_r, expect_y_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;

   // Next-state, counter and registered-output computation
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      reps_s    = reps_r;
      run_len_s = run_len_r;
      gap_len_s = gap_len_r;
      case (state_r)
         IDLE: begin
            if (abort) begin
               state_s = IDLE;
            end else if (start) begin
               run_len_s = run_len;
               gap_len_s = gap_len;
               reps_s    = reps;
               cnt_s     = run_len;
               if ((run_len == CNT_ZERO) || (reps == CNT_ZERO)) begin
                  state_s = DONE;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_s = IDLE;
            end else if (cnt_r == CNT_ONE) begin
               if (gap_len_r != CNT_ZERO) begin
                  state_s = GAP;
                  cnt_s   = gap_len_r;
               end else if (reps_r > CNT_ONE) begin
                  // back-to-back runs: the pair ends here since there is no gap
                  state_s = RUN;
                  cnt_s   = run_len_r;
                  reps_s  = reps_r - CNT_ONE;
               end else begin
                  state_s = DONE;
                  reps_s  = CNT_ZERO;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         GAP: begin
            if (abort) begin
               state_s = IDLE;
            end else if (cnt_r == CNT_ONE) begin
               if (reps_r > CNT_ONE) begin
                  state_s = RUN;
                  cnt_s   = run_len_r;
                  reps_s  = reps_r - CNT_ONE;
               end else begin
                  state_s = DONE;
                  reps_s  = CNT_ZERO;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      x_s          = (state_s == RUN);
      busy_s       = (state_s == RUN) || (state_s == GAP);
      done_s       = (state_s == DONE);
      streak_inc_s = (streak_r >= STK_MAX) ? streak_r : (streak_r + STK_ONE);
      if (x_s) begin
         streak_s = streak_inc_s;
      end else begin
         streak_s = STK_ZERO;
      end
      expect_y_s = x_s && (streak_s >= STK_MAX);
   end

   // State, counters, latched fields and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= CNT_ZERO;
         reps_r     <= CNT_ZERO;
         run_len_r  <= CNT_ZERO;
         gap_len_r  <= CNT_ZERO;
         streak_r   <= STK_ZERO;
         x_r        <= 1'b0;
         expect_y_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         reps_r     <= reps_s;
         run_len_r  <= run_len_s;
         gap_len_r  <= gap_len_s;
         streak_r   <= streak_s;
         x_r        <= x_s;
         expect_y_r <= expect_y_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
      end
   end

   assign x        = x_r;
   assign expect_y = expect_y_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule

// File: doc/run_generator.md
Name: run_generator

Overview:
- Serial stimulus transmitter that is the companion to the team's consecutive-ones detectors.
- Emits a programmed bit stream on serial output x: a run of ones followed by a gap of zeros, repeated N times.
- Also drives expect_y, the registered golden value of the detector output (1 on the 3rd and later consecutive 1).
- Sits upstream of any detector instance, in benches or on-board self-test.

Parameters:
W, 4, width of run_len, gap_len and reps fields and of their internal counters
STREAK, 3, consecutive-ones count at which expect_y asserts

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled at posedge only while in IDLE
abort  in  1  synchronous cancel; returns to IDLE without done
run_len  in  W  number of 1 bits per run; latched on accepted start
gap_len  in  W  number of 0 bits after each run; latched on accepted start
reps  in  W  number of run+gap pairs; latched on accepted start
x  out  1  serial bit stream, registered
expect_y  out  1  predicted detector output for the current x bit, registered
busy  out  1  high while the stream is being emitted
done  out  1  one-cycle pulse after the stream completes

Behaviour:
- Reset (async, rst=1): state=IDLE; x=0, expect_y=0, busy=0, done=0; all counters and latched fields =0. Takes effect immediately, including mid-stream.
- States:
  - IDLE: x=0, busy=0.
  - RUN: x=1.
  - GAP: x=0.
  - DONE: lasts one cycle.
- IDLE, start=1 at edge k:
  - Latch run_len, gap_len and reps.
  - If run_len==0 or reps==0: go to DONE, so done=1 in cycle k+1. No 1 bit is emitted and busy stays 0.
  - Otherwise: go to RUN, so x=1 and busy=1 from cycle k+1 (latency 1).
- RUN: emits exactly run_len cycles of x=1, then:
  - if gap_len>0: go to GAP;
  - else if reps remaining>1: start the next run immediately with a continuous x=1 stream;
  - else: go to DONE.
- GAP: emits exactly gap_len cycles of x=0. Then decrements reps remaining; if reps remaining>0 go to RUN, else go to DONE.
- The final run is followed by its full gap.
- DONE: done=1, busy=0, x=0 for one cycle, then IDLE.
- Total stream length is reps*(run_len+gap_len) cycles. done asserts in the cycle after the last stream bit.
- Streak counter (saturating at STREAK):
  - increments on each emitted x=1;
  - clears on any x=0 cycle, including IDLE and DONE;
  - is not reset between runs, so with gap_len=0 the streak spans runs.
- expect_y is 1 exactly when x=1 and that bit's streak count >=STREAK. It changes in the same cycle as x, with zero skew.
- Counters are W bits and count down from the latched values. The maximum values (2^W-1 for every field) must complete without wrap or overflow.
- start is ignored in RUN, GAP and DONE. The latched fields must not change mid-stream even if the inputs toggle.
- abort:
  - In RUN or GAP: next state is IDLE; x=0, expect_y=0, busy=0 from the next cycle; no done pulse; streak cleared.
  - In IDLE: abort has priority over start.
  - In DONE: ignored, and done still pulses.
- Simultaneous rst and anything else: rst wins.
- done and busy are never high in the same cycle.

Test Plan:
1. run_len=3, gap_len=1, reps=1, start at edge 0 -> cycles 1-4: x=1,1,1,0 and expect_y=0,0,1,0; busy=1 in cycles 1-4; done=1 in cycle 5 only.
2. run_len=5, gap_len=2, reps=2 -> x=1111100 1111100 (14 cycles); expect_y=1 on bits 3-5 of each run (6 cycles total); done in cycle 15.
3. run_len=2, gap_len=0, reps=3 -> x=1 for 6 consecutive cycles; expect_y=1 in cycles 3-6 (streak crosses run boundaries); done in cycle 7.
4. run_len=0, gap_len=4, reps=5 -> done=1 in cycle 1; x, busy and expect_y stay 0 throughout.
5. Interruptions:
   - run_len=8, gap_len=2, reps=3; assert abort in run cycle 4 -> x=0, busy=0 from the next cycle; no done; a new start with run_len=3 is accepted one cycle later.
   - Repeat with rst pulsed asynchronously mid-RUN -> x and busy go to 0 immediately, without waiting for a clock edge.
6. run_len=15, gap_len=15, reps=15, with start and the fields toggled randomly during the stream -> exactly 450 stream cycles, 15 runs of 15 ones each; expect_y=1 on 13 cycles per run; done in cycle 451; no counter wrap.
